fib_disp_scan: RTL and testbench

Downstream display stage for the Fibonacci datapath. Captures the four-digit BCD result and overflow flag on the datapath's one-cycle done pulse. Drives a four-digit, time-multiplexed, common-anode seven-segment display by scanning one digit at a time. Sits between the Fibonacci core outputs and the board LED pins.

---
 rtl/fib_disp_scan.sv | 127 ++++++++++++
 tb/tb_fib_disp_scan.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fib_disp_scan.sv
// Four-digit common-anode display scanner for Fibonacci BCD results; FIB_DISP_LZB_EN adds leading-zero blanking.
// Latency: capture on iDONE edge t, decoded segments and oVALID visible from edge t+1.
// Backpressure: none; a new result is accepted on any cycle iDONE is high.
module fib_disp_scan #(
    parameter int REFRESH_BITS = 18
) (
    input  logic       iCLK,
    input  logic       iRESET,
    input  logic       iDONE,
    input  logic       iOFLOW,
    input  logic [3:0] iBCD3,
    input  logic [3:0] iBCD2,
    input  logic [3:0] iBCD1,
    input  logic [3:0] iBCD0,
    output logic [3:0] oAN,
    output logic [6:0] oSEG,
    output logic       oDP,
    output logic       oVALID
);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    logic [REFRESH_BITS-1:0] cnt_q, cnt_d;
    logic [3:0][3:0]         dig_q, dig_d;
    logic                    ovf_q, ovf_d;
    logic                    valid_q, valid_d;
    logic [3:0]              an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic                    vld_out_q, vld_out_d;
    logic [1:0]              sel;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
        logic [6:0] seg;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = SEG_DASH;
        endcase
        return seg;
    endfunction

    assign sel = cnt_q[REFRESH_BITS-1 -: 2];

    always_comb begin
        cnt_d   = cnt_q + REFRESH_BITS'(1);
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        if (iDONE) begin
            dig_d   = {iBCD3, iBCD2, iBCD1, iBCD0};
            ovf_d   = iOFLOW;
            valid_d = 1'b1;
        end
    end

`ifdef FIB_DISP_LZB_EN
    // A digit is blank when it and every more significant digit are zero.
    logic [3:0] blank;
    always_comb begin
        blank    = 4'b0000;
        blank[3] = (dig_q[3] == 4'd0);
        blank[2] = blank[3] && (dig_q[2] == 4'd0);
        blank[1] = blank[2] && (dig_q[1] == 4'd0);
    end
`endif

    // Decode uses the pre-capture registers, so a new result shows one edge later.
    always_comb begin
        an_d      = 4'b1111;
        seg_d     = SEG_BLANK;
        dp_d      = 1'b1;
        vld_out_d = valid_q;
        if (valid_q) begin
            an_d = ~(4'b0001 << sel);
            if (ovf_q) begin
                seg_d = SEG_DASH;
                dp_d  = (sel != 2'd0);
            end else begin
                seg_d = bcd_to_seg(dig_q[sel]);
`ifdef FIB_DISP_LZB_EN
                if (blank[sel]) begin
                    an_d  = 4'b1111;
                    seg_d = SEG_BLANK;
                end
`endif
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            cnt_q     <= '0;
            dig_q     <= '0;
            ovf_q     <= 1'b0;
            valid_q   <= 1'b0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
            dp_q      <= 1'b1;
            vld_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            dig_q     <= dig_d;
            ovf_q     <= ovf_d;
            valid_q   <= valid_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            vld_out_q <= vld_out_d;
        end
    end

    assign oAN    = an_q;
    assign oSEG   = seg_q;
    assign oDP    = dp_q;
    assign oVALID = vld_out_q;

endmodule

// File: tb/tb_fib_disp_scan.sv
// Directed bench for fib_disp_scan at REFRESH_BITS=4 (16-cycle scan, 4 cycles per digit).
module tb_fib_disp_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       done;
    logic       oflow;
    logic [3:0] bcd3, bcd2, bcd1, bcd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       vld;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    fib_disp_scan #(.REFRESH_BITS(4)) dut (
        .iCLK   (clk),
        .iRESET (rst),
        .iDONE  (done),
        .iOFLOW (oflow),
        .iBCD3  (bcd3),
        .iBCD2  (bcd2),
        .iBCD1  (bcd1),
        .iBCD0  (bcd0),
        .oAN    (an),
        .oSEG   (seg),
        .oDP    (dp),
        .oVALID (vld)
    );

    always #5 clk = ~clk;

    // Edges since reset; the outputs after edge k show the slot of count k-1.
    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Returns at the negedge of the first cycle in which digit k's slot is displayed.
    task automatic wait_slot(input int k);
        bit found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (((cyc + 15) % 16) == 4 * k) found = 1;
        end
        if (!found) chk("slot timeout", 16'd0, 16'd1);
    endtask

    task automatic check_slot(input string tag, input int k, input logic [3:0] e_an,
                              input logic [6:0] e_seg, input logic e_dp);
        wait_slot(k);
        chk({tag, " an"},  16'(an),  16'(e_an));
        chk({tag, " seg"}, 16'(seg), 16'(e_seg));
        chk({tag, " dp"},  16'(dp),  16'(e_dp));
    endtask

    // Drives one result at the current negedge and drops iDONE at the next.
    task automatic pulse(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                         input logic [3:0] d0, input logic ov);
        done = 1'b1; oflow = ov;
        bcd3 = d3; bcd2 = d2; bcd1 = d1; bcd0 = d0;
        @(negedge clk);
        done = 1'b0; oflow = 1'b0;
    endtask

    initial begin
        rst = 1'b1; done = 1'b0; oflow = 1'b0;
        bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset: dark display for 64 cycles
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            chk("reset dark", {3'd0, an, seg, dp, vld}, {3'd0, 4'b1111, 7'h7F, 1'b1, 1'b0});
        end

        // Capture 0144
        @(negedge clk);
        pulse(4'd0, 4'd1, 4'd4, 4'd4, 1'b0);
        chk("valid lag", 16'(vld), 16'd0);
        @(negedge clk);
        chk("valid rise", 16'(vld), 16'd1);
        check_slot("0144 d0", 0, 4'b1110, 7'b0011001, 1'b1);
        check_slot("0144 d1", 1, 4'b1101, 7'b0011001, 1'b1);
        check_slot("0144 d2", 2, 4'b1011, 7'b1111001, 1'b1);
`ifdef FIB_DISP_LZB_EN
        check_slot("0144 d3", 3, 4'b1111, 7'h7F, 1'b1);
`else
        check_slot("0144 d3", 3, 4'b0111, 7'b1000000, 1'b1);
`endif

        // Overflow 9999, then per-cycle scan walk with wrap
        @(negedge clk);
        pulse(4'd9, 4'd9, 4'd9, 4'd9, 1'b1);
        wait_slot(0);
        for (int i = 0; i < 20; i++) begin
            logic [3:0] e_an;
            e_an = (i % 16) < 4  ? 4'b1110 :
                   (i % 16) < 8  ? 4'b1101 :
                   (i % 16) < 12 ? 4'b1011 : 4'b0111;
            chk("ovf scan an",  16'(an),  16'(e_an));
            chk("ovf scan seg", 16'(seg), 16'(7'b0111111));
            chk("ovf scan dp",  16'(dp),  16'((i % 16) < 4 ? 1'b0 : 1'b1));
            @(negedge clk);
        end

        // Remaining glyphs: 9,7,6,A
        pulse(4'd9, 4'd7, 4'd6, 4'hA, 1'b0);
        check_slot("976A d0", 0, 4'b1110, 7'b0111111, 1'b1);
        check_slot("976A d1", 1, 4'b1101, 7'b0000010, 1'b1);
        check_slot("976A d2", 2, 4'b1011, 7'b1111000, 1'b1);
        check_slot("976A d3", 3, 4'b0111, 7'b0010000, 1'b1);

        // Reset priority over iDONE mid-scan
        @(negedge clk);
        rst = 1'b1; done = 1'b1; bcd3 = 4'd5; bcd2 = 4'd5; bcd1 = 4'd5; bcd0 = 4'd5;
        @(negedge clk);
        chk("rstprio dark", {3'd0, an, seg, dp, vld}, {3'd0, 4'b1111, 7'h7F, 1'b1, 1'b0});
        rst = 1'b0; done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("rstprio hold", {11'd0, an, vld}, {11'd0, 4'b1111, 1'b0});
        end
        pulse(4'd2, 4'd3, 4'd4, 4'd5, 1'b0);
        check_slot("2345 d0", 0, 4'b1110, 7'b0010010, 1'b1);
        check_slot("2345 d1", 1, 4'b1101, 7'b0011001, 1'b1);
        check_slot("2345 d2", 2, 4'b1011, 7'b0110000, 1'b1);
        check_slot("2345 d3", 3, 4'b0111, 7'b0100100, 1'b1);

        // Recapture 0008 -> 0013 during the digit-1 slot
        @(negedge clk);
        pulse(4'd0, 4'd0, 4'd0, 4'd8, 1'b0);
        check_slot("0008 d0", 0, 4'b1110, 7'b0000000, 1'b1);
`ifdef FIB_DISP_LZB_EN
        check_slot("0008 d1", 1, 4'b1111, 7'h7F, 1'b1);
`else
        check_slot("0008 d1", 1, 4'b1101, 7'b1000000, 1'b1);
`endif
        pulse(4'd0, 4'd0, 4'd1, 4'd3, 1'b0);
`ifdef FIB_DISP_LZB_EN
        chk("recap old", {5'd0, an, seg}, {5'd0, 4'b1111, 7'h7F});
`else
        chk("recap old", {5'd0, an, seg}, {5'd0, 4'b1101, 7'b1000000});
`endif
        @(negedge clk);
        chk("recap new", {5'd0, an, seg}, {5'd0, 4'b1101, 7'b1111001});
        check_slot("0013 d0", 0, 4'b1110, 7'b0110000, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
